// File: rtl/seq_detect_1011_if.sv
// Serial-bit input, match pulse and counter outputs of the 1011 detector.
// The master side drives the bit stream and the slave side is the detector.
interface seq_detect_1011_if #(
  parameter int CNT_W = 8
);
  logic             din;
  logic             en;
  logic             clear;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;
  logic [2:0]       state;

  modport master (
    output din, en, clear,
    input  match, match_cnt, cnt_sat, state
  );

  modport slave (
    input  din, en, clear,
    output match, match_cnt, cnt_sat, state
  );
endinterface

// File: rtl/seq_detect_1011.sv
// Overlapping 1011 Moore detector with saturating match counter; match rises one clock after the final 1.
// No backpressure: a bit is consumed on every edge with en=1, and en=0 simply freezes the FSM.
module seq_detect_1011 #(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  seq_detect_1011_if.slave    bus
);

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      S0:      if (bus.en) state_d = bus.din ? S1    : S0;
      S1:      if (bus.en) state_d = bus.din ? S1    : S10;
      S10:     if (bus.en) state_d = bus.din ? S101  : S0;
      S101:    if (bus.en) state_d = bus.din ? S1011 : S10;
      S1011:   if (bus.en) state_d = bus.din ? S1    : S10;
      // Codes 5-7 recover to idle even while en is low.
      default: state_d = S0;
    endcase

    // S1011 has no self-loop, so this fires only on the entering edge.
    match_d = bus.en && (state_d == S1011);

    // A detection on a clearing edge is kept as the first count.
    if (bus.clear) begin
      cnt_d = match_d ? CNT_ONE : '0;
    end else if (match_d && !sat_q) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    sat_d = &cnt_d;
  end

  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.cnt_sat   = sat_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_seq_detect_1011.sv
// Directed bench for seq_detect_1011: a history-based reference model feeds a scoreboard queue;
// a CNT_W=8 and a CNT_W=2 instance receive the same stimulus.
module tb_seq_detect_1011;

  logic clk = 1'b0;
  logic reset;

  seq_detect_1011_if #(.CNT_W(8)) bus8 ();
  seq_detect_1011_if #(.CNT_W(2)) bus2 ();

  seq_detect_1011 #(.CNT_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  seq_detect_1011 #(.CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;

  typedef struct {
    logic m;
    int   cnt8;
    int   cnt2;
    int   st;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] hist;
  int         cnt_m;
  int         total;
  int         bad;

  // Progress is the longest suffix of the valid-bit history that is a prefix of 1011.
  function automatic int model_state(input logic [3:0] h);
    if (h == 4'b1011)      return 4;
    if (h[2:0] == 3'b101)  return 3;
    if (h[1:0] == 2'b10)   return 2;
    if (h[0])              return 1;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic d, input logic e, input logic c);
    exp_t x;
    logic m;
    reset      = r;
    bus8.din   = d;  bus8.en = e;  bus8.clear = c;
    bus2.din   = d;  bus2.en = e;  bus2.clear = c;
    if (!r) begin
      hist  = 4'b0000;
      cnt_m = 0;
      m     = 1'b0;
    end else begin
      if (e) hist = {hist[2:0], d};
      m = e && (model_state(hist) == 4);
      if (c)      cnt_m = m ? 1 : 0;
      else if (m) cnt_m = cnt_m + 1;
    end
    x.m    = m;
    x.cnt8 = (cnt_m > 255) ? 255 : cnt_m;
    x.cnt2 = (cnt_m > 3) ? 3 : cnt_m;
    x.st   = model_state(hist);
    sb.push_back(x);

    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("match8", 32'(bus8.match), 32'(x.m));
    check("cnt8",   32'(bus8.match_cnt), x.cnt8);
    check("sat8",   32'(bus8.cnt_sat), (x.cnt8 == 255) ? 1 : 0);
    check("state8", 32'(bus8.state), x.st);
    check("match2", 32'(bus2.match), 32'(x.m));
    check("cnt2",   32'(bus2.match_cnt), x.cnt2);
    check("sat2",   32'(bus2.cnt_sat), (x.cnt2 == 3) ? 1 : 0);
  endtask

  // Feeds n bits MSB first, each followed by gap idle (en=0) cycles.
  task automatic feed(input logic [15:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b1, 1'b0);
      for (int g = 0; g < gap; g++) step(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    hist  = 4'b0000;
    cnt_m = 0;

    // Reset for two cycles, then overlapping 1011011.
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    feed(16'b1011011, 7, 0);
    check("cnt_after_1011011", 32'(bus8.match_cnt), 2);

    // No match in 100110010, ends in S10.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    feed(16'b100110010, 9, 0);
    check("state_after_100110010", 32'(bus8.state), 2);
    check("cnt_after_100110010", 32'(bus8.match_cnt), 0);

    // 1011 with three idle cycles after each bit.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    feed(16'b1011, 4, 3);
    check("cnt_after_gapped_1011", 32'(bus8.match_cnt), 1);

    // Five gapped detections: the narrow counter saturates at 3.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      feed(16'b1011, 4, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end
    check("cnt2_saturated", 32'(bus2.match_cnt), 3);
    check("sat2_saturated", 32'(bus2.cnt_sat), 1);
    check("cnt8_five", 32'(bus8.match_cnt), 5);

    // Clear on a non-matching edge, then clear together with a detection.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("cnt_after_clear", 32'(bus8.match_cnt), 0);
    feed(16'b101, 3, 0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("match_on_clear_edge", 32'(bus8.match), 1);
    check("cnt_on_clear_edge", 32'(bus8.match_cnt), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("match_one_cycle", 32'(bus8.match), 0);

    // Reset mid-pattern drops progress; reset beats a completing 1.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    feed(16'b101, 3, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("state_after_reset_mid", 32'(bus8.state), 1);
    feed(16'b01, 2, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("match_reset_priority", 32'(bus8.match), 0);
    check("state_reset_priority", 32'(bus8.state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
